// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative data cache: FSM states,
// access-width encodings and the byte-lane load/store functions.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_REFILL
    } state_t;

    localparam logic [2:0] UBHW_LB  = 3'b000;
    localparam logic [2:0] UBHW_LH  = 3'b001;
    localparam logic [2:0] UBHW_LW  = 3'b010;
    localparam logic [2:0] UBHW_LBU = 3'b100;
    localparam logic [2:0] UBHW_LHU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    // Width of an index into n entries; never zero so single-entry cases still get a 1-bit field.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic size_t access_size(input logic [2:0] ubhw);
        case (ubhw[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] ubhw, input logic [1:0] byte_ofs);
        case (access_size(ubhw))
            SZ_HALF: return byte_ofs[0];
            SZ_WORD: return byte_ofs != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  byte_ofs,
                                                input logic [2:0]  ubhw);
        logic [31:0] shifted;
        logic        sext;
        shifted = word >> {byte_ofs, 3'b000};
        sext    = ~ubhw[2];
        case (access_size(ubhw))
            SZ_BYTE: return {{24{sext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: return {{16{sext & shifted[15]}}, shifted[15:0]};
            default: return word;
        endcase
    endfunction

    // Stores ignore the signedness bit; only the width selects the lanes.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] din,
                                                input logic [1:0]  byte_ofs,
                                                input logic [2:0]  ubhw);
        logic [31:0] merged;
        merged = old;
        case (access_size(ubhw))
            SZ_BYTE: merged[{byte_ofs, 3'b000} +: 8]        = din[7:0];
            SZ_HALF: merged[{byte_ofs[1], 4'b0000} +: 16]   = din[15:0];
            default: merged                                 = din;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age tracking: each set holds a permutation of ages 0..WAYS-1,
// age 0 is most recently used and the way at age WAYS-1 is the victim.
module cache_lru
    import cache_pkg::*;
#(
    parameter  int WAYS  = 2,
    parameter  int SETS  = 32,
    localparam int WAY_W = clog2_min1(WAYS),
    localparam int IDX_W = clog2_min1(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    input  logic             upd,
    input  logic [WAY_W-1:0] hit_way,
    output logic [WAY_W-1:0] victim
);

    logic [WAY_W-1:0] age [SETS][WAYS];
    logic [WAY_W-1:0] old_age;

    assign old_age = age[idx][hit_way];

    always_comb begin
        victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age[idx][w] == WAY_W'(WAYS - 1))
                victim = WAY_W'(w);
        end
    end

    // NOTE: this small storage array is reset on purpose -- victim selection
    // relies on every set holding a valid age permutation from the first access.
    // NOTE: sequential state uses non-blocking assignments so all ways of the
    // set update from the same pre-edge ages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age[s][w] <= WAY_W'(w);
        end else if (upd) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == hit_way)
                    age[idx][w] <= '0;
                else if (age[idx][w] < old_age)
                    age[idx][w] <= age[idx][w] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative write-back/write-allocate data cache with an
// integrated miss FSM doing word-serial writeback and refill.
module assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_BITS  = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [2:0]           cpu_u_b_h_w,
    input  logic [31:0]          cpu_din,
    output logic [31:0]          cpu_dout,
    output logic                 cpu_ack,
    output logic                 cpu_err,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ack,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFS_W  = WORD_W + 2;
    localparam int IDX_W  = clog2_min1(SETS);
    localparam int TAG_W  = ADDR_BITS - IDX_W - OFS_W;
    localparam int WAY_W  = clog2_min1(WAYS);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

    state_t state, state_d;

    logic                 req_we;
    logic [ADDR_BITS-1:0] req_addr;
    logic [2:0]           req_ubhw;
    logic [31:0]          req_din;
    logic                 post_refill;
    logic [WAY_W-1:0]     victim_way;
    logic [WORD_W-1:0]    cnt;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_word;
    logic [1:0]        req_byte;

    assign req_tag  = req_addr[ADDR_BITS-1 -: TAG_W];
    assign req_idx  = req_addr[OFS_W +: IDX_W];
    assign req_word = req_addr[2 +: WORD_W];
    assign req_byte = req_addr[1:0];

    logic [WAYS-1:0]  valid   [SETS];
    logic [WAYS-1:0]  dirty   [SETS];
    logic [TAG_W-1:0] tag_mem [SETS][WAYS];
    logic [31:0]      data_mem[SETS][WAYS][LINE_WORDS];

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] lru_victim;
    logic [WAY_W-1:0] victim_sel;
    logic             free_found;
    logic [31:0]      hit_word;

    logic accept, lookup_err, lookup_hit, lookup_miss, word_done, refill_word;

    cache_lru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clk     (clk),
        .rst     (rst),
        .idx     (req_idx),
        .upd     (lookup_hit),
        .hit_way (hit_way),
        .victim  (lru_victim)
    );

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // An empty way always beats evicting a live line.
    always_comb begin
        victim_sel = lru_victim;
        free_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid[req_idx][w] && !free_found) begin
                victim_sel = WAY_W'(w);
                free_found = 1'b1;
            end
        end
    end

    assign hit_word    = data_mem[req_idx][hit_way][req_word];
    assign refill_word = (state == ST_REFILL) && word_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_d;
    end

    // NOTE: combinational process uses blocking assignments with every output
    // defaulted first, so no path through the case can infer a latch.
    always_comb begin
        state_d     = state;
        accept      = 1'b0;
        lookup_err  = 1'b0;
        lookup_hit  = 1'b0;
        lookup_miss = 1'b0;
        word_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_req && !cpu_ack) begin
                    accept  = 1'b1;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (misaligned(req_ubhw, req_byte)) begin
                    lookup_err = 1'b1;
                    state_d    = ST_IDLE;
                end else if (hit) begin
                    lookup_hit = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    lookup_miss = 1'b1;
                    state_d     = (valid[req_idx][victim_sel] && dirty[req_idx][victim_sel])
                                  ? ST_WRITEBACK : ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                if (mem_req && mem_ack) begin
                    word_done = 1'b1;
                    if (cnt == LAST_WORD) state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (mem_req && mem_ack) begin
                    word_done = 1'b1;
                    if (cnt == LAST_WORD) state_d = ST_LOOKUP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_we      <= 1'b0;
            req_addr    <= '0;
            req_ubhw    <= '0;
            req_din     <= '0;
            post_refill <= 1'b0;
            victim_way  <= '0;
            cnt         <= '0;
            cpu_dout    <= '0;
            cpu_ack     <= 1'b0;
            cpu_err     <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
            end
        end else begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;

            if (accept) begin
                req_we      <= cpu_we;
                req_addr    <= cpu_addr;
                req_ubhw    <= cpu_u_b_h_w;
                req_din     <= cpu_din;
                post_refill <= 1'b0;
            end

            if (lookup_err) begin
                cpu_ack <= 1'b1;
                cpu_err <= 1'b1;
            end

            if (lookup_hit) begin
                cpu_ack <= 1'b1;
                if (req_we) dirty[req_idx][hit_way] <= 1'b1;
                else        cpu_dout <= load_extend(hit_word, req_byte, req_ubhw);
                if (!post_refill && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            end

            if (lookup_miss) begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
                victim_way <= victim_sel;
                cnt        <= '0;
            end

            // Each word: raise mem_req, wait for mem_ack, then one idle cycle.
            if (state == ST_WRITEBACK || state == ST_REFILL) begin
                if (word_done) begin
                    mem_req <= 1'b0;
                    cnt     <= cnt + 1'b1;
                    if (refill_word && cnt == LAST_WORD) begin
                        valid[req_idx][victim_way] <= 1'b1;
                        dirty[req_idx][victim_way] <= 1'b0;
                        post_refill                <= 1'b1;
                    end
                end else if (!mem_req) begin
                    mem_req   <= 1'b1;
                    mem_we    <= (state == ST_WRITEBACK);
                    mem_addr  <= (state == ST_WRITEBACK)
                                 ? {tag_mem[req_idx][victim_way], req_idx, cnt, 2'b00}
                                 : {req_tag, req_idx, cnt, 2'b00};
                    mem_wdata <= data_mem[req_idx][victim_way][cnt];
                end
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits guard their contents.
    always_ff @(posedge clk) begin
        if (lookup_hit && req_we)
            data_mem[req_idx][hit_way][req_word] <= store_merge(hit_word, req_din, req_byte, req_ubhw);
        if (refill_word) begin
            data_mem[req_idx][victim_way][cnt] <= mem_rdata;
            if (cnt == LAST_WORD) tag_mem[req_idx][victim_way] <= req_tag;
        end
    end

endmodule

// File: doc/assoc_cache.md
Name: assoc_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache with an integrated miss-handling FSM.
- Sits between the CPU memory stage and main memory, replacing the external cache-manager FSM and the fixed 2-way array.
- Adds configurable ways, sets and line size, true-LRU age replacement, word-serial writeback and refill, a misaligned-access error flag, and hit/miss counters.

Parameters:
ADDR_BITS, 32, byte address width
WAYS, 2, associativity; power of 2, 1..8
SETS, 32, sets; power of 2
LINE_WORDS, 4, 32-bit words per line; power of 2, at least 2
Derived: OFS_W = log2(LINE_WORDS)+2, IDX_W = log2(SETS), TAG_W = ADDR_BITS-IDX_W-OFS_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
cpu_req  in  1  request; held until cpu_ack
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_BITS  byte address
cpu_u_b_h_w  in  3  width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; bit2 ignored on stores
cpu_din  in  32  store data, right-aligned
cpu_dout  out  32  load data, extended per cpu_u_b_h_w
cpu_ack  out  1  one-cycle completion pulse
cpu_err  out  1  misaligned access; valid with cpu_ack
mem_req  out  1  memory word request
mem_we  out  1  1 = writeback word, 0 = refill word
mem_addr  out  ADDR_BITS  word-aligned address
mem_wdata  out  32  writeback data
mem_rdata  in  32  refill data, sampled on mem_ack
mem_ack  in  1  one-cycle completion of the current word
hit_cnt  out  32  first-lookup hits, saturating
miss_cnt  out  32  misses, saturating

Behaviour:
- Address split: tag = [ADDR_BITS-1 : IDX_W+OFS_W], index = [IDX_W+OFS_W-1 : OFS_W], word = [OFS_W-1 : 2], byte = [1:0].
- Reset (rst=0, asynchronous):
  - state IDLE; all valid and dirty bits 0.
  - Way i age = i in every set.
  - cpu_ack, cpu_err, mem_req, mem_we = 0; cpu_dout, mem_addr, mem_wdata = 0; counters = 0.
  - Data and tag arrays are not reset.
  - Reset mid-transfer abandons the transfer; mem_req drops immediately.
- IDLE:
  - Accepts cpu_req when cpu_ack = 0, registers the request and moves to LOOKUP.
  - Requests are therefore accepted at most every 2nd cycle.
- LOOKUP, misaligned access (LH/LHU with addr[0]=1, or LW with addr[1:0]≠0):
  - Next edge: cpu_ack = 1, cpu_err = 1, return to IDLE.
  - No array or counter change.
- LOOKUP, hit (valid & tag match, at most one way):
  - Next edge: cpu_ack = 1, return to IDLE; hit latency is 1 cycle after acceptance.
  - Load: cpu_dout gets the selected byte, half or word, sign- or zero-extended.
  - Store: merge the selected byte lanes, set dirty.
  - LRU update: hit way age = 0; ways with age below the old age increment.
  - hit_cnt increments only if this is not a post-refill lookup.
- LOOKUP, miss:
  - miss_cnt increments.
  - Victim = lowest-index invalid way, otherwise the way with age WAYS-1.
  - Victim valid & dirty → WRITEBACK, else → REFILL. Word counter reset to 0.
- WRITEBACK:
  - Per word: mem_req = 1, mem_we = 1, mem_addr = {victim tag, index, cnt, 2'b00}, mem_wdata = line[cnt].
  - On mem_ack: mem_req = 0 for one cycle, then cnt increments.
  - After word LINE_WORDS-1 → REFILL with cnt = 0.
- REFILL:
  - Same handshake with mem_we = 0 and the request tag.
  - line[cnt] = mem_rdata on mem_ack.
  - After the last word: tag written, valid = 1, dirty = 0, go to LOOKUP flagged as post-refill; that lookup hits.
- cpu_req must stay stable from acceptance until cpu_ack; any change is ignored.
- Counters hold at 0xFFFF_FFFF.
- WAYS = 1: age logic degenerates; the victim is always way 0.

Decomposition:
- Package cache_pkg:
  - state encoding IDLE/LOOKUP/WRITEBACK/REFILL
  - u_b_h_w encodings
  - clog2-based width helpers
  - load-extend and store-merge functions
- Sub-module cache_lru (parameter WAYS):
  - per-set age storage
  - update on hit-way strobe
  - victim-way output

Test Plan (WAYS=2, SETS=32, LINE_WORDS=4 unless noted):
1. Cold LW 0x104 → mem reads at 0x100, 0x104, 0x108, 0x10C; cpu_dout = mem[0x104]; miss_cnt = 1. Repeat LW 0x104 → cpu_ack 1 cycle after acceptance, no mem_req, hit_cnt = 1.
2. mem[0x200] = 0x8081F0F0:
   - LB 0x200 → 0xFFFFFFF0
   - LBU 0x203 → 0x00000080
   - LH 0x202 → 0xFFFF8081
   - LHU 0x202 → 0x00008081
3. SB 0x100 = 0xAA, then LW 0x300 (same index 16, fills way 1), then LW 0x500 → 4 writes at 0x100..0x10C with byte0 of the first word = 0xAA, then 4 reads at 0x500..0x50C.
4. WAYS=4: fill tags A, B, C, D in set 0, re-read A then B, load new tag E → victim is C's way; subsequent read of C misses.
5. LW 0x102 → cpu_ack and cpu_err the cycle after acceptance; no mem_req; hit_cnt and miss_cnt unchanged.
6. Assert rst after the 2nd refill mem_ack → mem_req = 0 asynchronously; after release, LW to the same address misses and refills all 4 words.
